// File: rtl/cafe_pkg.sv
// Shared constants for the coffee-machine datapath: controller strobe and condition bit
// positions, plus the drink-select encoding.
package cafe_pkg;

  localparam int unsigned CTRL_CLR_CREDIT  = 0;
  localparam int unsigned CTRL_LOAD_SEL    = 1;
  localparam int unsigned CTRL_DEDUCT      = 2;
  localparam int unsigned CTRL_START_TIMER = 3;
  localparam int unsigned CTRL_WATER       = 4;
  localparam int unsigned CTRL_COFFEE      = 5;
  localparam int unsigned CTRL_MILK        = 6;
  localparam int unsigned CTRL_CHANGE_STEP = 7;

  localparam int unsigned COND_AFFORD       = 0;
  localparam int unsigned COND_SEL_VALID    = 1;
  localparam int unsigned COND_DONE         = 2;
  localparam int unsigned COND_CHANGE_AVAIL = 3;
  localparam int unsigned COND_CANCEL       = 4;
  localparam int unsigned COND_FAULT        = 5;

  typedef enum logic [1:0] {
    DrinkNone = 2'd0,
    Drink1    = 2'd1,
    Drink2    = 2'd2,
    Drink3    = 2'd3
  } drink_sel_e;

endpackage

// File: rtl/cafe_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse, one lane per bit.
module cafe_sync_edge #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] sync1_q, sync1_d;
  logic [Width-1:0] sync2_q, sync2_d;
  logic [Width-1:0] rise_q, rise_d;

  always_comb begin
    sync1_d = async_i;
    sync2_d = sync1_q;
    rise_d  = sync1_q & ~sync2_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/maquina_cafe_datapath.sv
// Coffee-machine datapath: credit, drink select, dispense timer and fault under controller strobes.
// Optional cancel latch built when CAFE_CANCEL_EN is defined.
module maquina_cafe_datapath
  import cafe_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 12,
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned COIN_A      = 100,
  parameter int unsigned COIN_B      = 500,
  parameter int unsigned CHANGE_UNIT = 100,
  parameter int unsigned PRICE1      = 300,
  parameter int unsigned PRICE2      = 400,
  parameter int unsigned PRICE3      = 500,
  parameter int unsigned TIME1       = 40,
  parameter int unsigned TIME2       = 60,
  parameter int unsigned TIME3       = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          ctrl,
  input  logic [1:0]          coin_in,
  input  logic [1:0]          sel_in,
  input  logic                cancel_in,
  output logic [5:0]          cond,
  output logic [CREDIT_W-1:0] credit,
  output logic                water,
  output logic                coffee,
  output logic                milk,
  output logic                change_out
);

  localparam int unsigned CW = CREDIT_W + 2;
  localparam logic [CW-1:0] CreditMax = {2'b00, {CREDIT_W{1'b1}}};

  function automatic logic [CW-1:0] price_of(input drink_sel_e s);
    case (s)
      Drink1:  price_of = CW'(PRICE1);
      Drink2:  price_of = CW'(PRICE2);
      Drink3:  price_of = CW'(PRICE3);
      default: price_of = '0;
    endcase
  endfunction

  function automatic logic [TIMER_W-1:0] time_of(input drink_sel_e s);
    case (s)
      Drink1:  time_of = TIMER_W'(TIME1);
      Drink2:  time_of = TIMER_W'(TIME2);
      Drink3:  time_of = TIMER_W'(TIME3);
      default: time_of = '0;
    endcase
  endfunction

  logic [1:0] coin_lvl_unused;
  logic [1:0] coin_rise;
  logic [1:0] sel_sync;
  logic [1:0] sel_rise_unused;
  logic       cancel_rise;

  cafe_sync_edge #(.Width(2)) u_sync_coin (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (coin_in),
    .level_o (coin_lvl_unused),
    .rise_o  (coin_rise)
  );

  cafe_sync_edge #(.Width(2)) u_sync_sel (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (sel_in),
    .level_o (sel_sync),
    .rise_o  (sel_rise_unused)
  );

`ifdef CAFE_CANCEL_EN
  logic cancel_lvl_unused;

  cafe_sync_edge #(.Width(1)) u_sync_cancel (
    .clk_i   (clk),
    .rst_ni  (rst),
    .async_i (cancel_in),
    .level_o (cancel_lvl_unused),
    .rise_o  (cancel_rise)
  );
`else
  logic cancel_in_unused;
  assign cancel_in_unused = cancel_in;
  assign cancel_rise      = 1'b0;
`endif

  logic [CREDIT_W-1:0] credit_q, credit_d;
  drink_sel_e          sel_q, sel_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                armed_q, armed_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic                cancel_q, cancel_d;
  logic [5:0]          cond_q, cond_d;
  logic [2:0]          act_q, act_d;
  logic                change_q, change_d;

  logic [CW-1:0] coin_sum, gross, price, deduct_amt, change_amt, net;
  logic          deduct_skip, change_ok, forfeit;

  always_comb begin
    coin_sum = '0;
    if (coin_rise[0]) coin_sum = coin_sum + CW'(COIN_A);
    if (coin_rise[1]) coin_sum = coin_sum + CW'(COIN_B);
    gross = {2'b00, credit_q} + coin_sum;
    price = price_of(sel_q);

    deduct_amt  = '0;
    change_amt  = '0;
    deduct_skip = 1'b0;
    change_ok   = 1'b0;
    forfeit     = 1'b0;

    if (ctrl[CTRL_DEDUCT] && (sel_q != DrinkNone)) begin
      if (gross < price) deduct_skip = 1'b1;
      else               deduct_amt  = price;
    end
    if (ctrl[CTRL_CHANGE_STEP]) begin
      if ({2'b00, credit_q} >= CW'(CHANGE_UNIT)) begin
        change_ok  = 1'b1;
        change_amt = CW'(CHANGE_UNIT);
      end else begin
        forfeit = 1'b1;
      end
    end

    // A forfeited remainder is dropped, but coins landing that same cycle are still credited.
    net = forfeit ? coin_sum : (gross - deduct_amt - change_amt);

    fault_d = fault_q | deduct_skip;
    if (net[CW-1]) begin
      credit_d = '0;
    end else if (net > CreditMax) begin
      credit_d = '1;
      fault_d  = 1'b1;
    end else begin
      credit_d = net[CREDIT_W-1:0];
    end

    cancel_d = cancel_q | cancel_rise;

    if (ctrl[CTRL_CLR_CREDIT]) begin
      credit_d  = '0;
      fault_d   = 1'b0;
      cancel_d  = 1'b0;
      change_ok = 1'b0;
    end
    change_d = change_ok;

    sel_d = ctrl[CTRL_LOAD_SEL] ? drink_sel_e'(sel_sync) : sel_q;

    timer_d = timer_q;
    done_d  = done_q;
    armed_d = armed_q;
    if (ctrl[CTRL_START_TIMER]) begin
      timer_d = time_of(sel_q);
      done_d  = 1'b0;
      armed_d = 1'b1;
    end else begin
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      // armed covers both the 1->0 step and a zero-length start
      if (armed_q && (timer_q <= TIMER_W'(1))) begin
        done_d  = 1'b1;
        armed_d = 1'b0;
      end
    end

    cond_d = '0;
    cond_d[COND_AFFORD]       = (sel_d != DrinkNone) && ({2'b00, credit_d} >= price_of(sel_d));
    cond_d[COND_SEL_VALID]    = (sel_d != DrinkNone);
    cond_d[COND_DONE]         = done_d;
    cond_d[COND_CHANGE_AVAIL] = ({2'b00, credit_d} >= CW'(CHANGE_UNIT));
    cond_d[COND_CANCEL]       = cancel_d;
    cond_d[COND_FAULT]        = fault_d;

    act_d = ctrl[CTRL_MILK:CTRL_WATER] & {3{~fault_d}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= '0;
      sel_q    <= DrinkNone;
      timer_q  <= '0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      cancel_q <= 1'b0;
      cond_q   <= '0;
      act_q    <= '0;
      change_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      cancel_q <= cancel_d;
      cond_q   <= cond_d;
      act_q    <= act_d;
      change_q <= change_d;
    end
  end

  assign cond       = cond_q;
  assign credit     = credit_q;
  assign water      = act_q[0];
  assign coffee     = act_q[1];
  assign milk       = act_q[2];
  assign change_out = change_q;

endmodule

// File: tb/tb_maquina_cafe_datapath.sv
// Self-checking bench for maquina_cafe_datapath: cycle vector table plus directed corner sequences.
module tb_maquina_cafe_datapath;

`ifdef CAFE_CANCEL_EN
  localparam logic CancelExp = 1'b1;
`else
  localparam logic CancelExp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ctrl = '0, ctrl_b = '0;
  logic [1:0]  coin_in = '0, coin_b = '0;
  logic [1:0]  sel_in = '0;
  logic        cancel_in = 1'b0;
  logic [5:0]  cond, cond_b;
  logic [11:0] credit, credit_b;
  logic        water, coffee, milk, change_out;
  logic        water_b, coffee_b, milk_b, change_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maquina_cafe_datapath u_dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .coin_in    (coin_in),
    .sel_in     (sel_in),
    .cancel_in  (cancel_in),
    .cond       (cond),
    .credit     (credit),
    .water      (water),
    .coffee     (coffee),
    .milk       (milk),
    .change_out (change_out)
  );

  // Second instance with a 50-unit coin so odd change remainders are reachable.
  maquina_cafe_datapath #(.COIN_A(50)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl_b),
    .coin_in    (coin_b),
    .sel_in     (sel_in),
    .cancel_in  (cancel_in),
    .cond       (cond_b),
    .credit     (credit_b),
    .water      (water_b),
    .coffee     (coffee_b),
    .milk       (milk_b),
    .change_out (change_b)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic [1:0]  coin;
    logic [1:0]  sel;
    logic [11:0] credit;
    logic [5:0]  cond;
    logic [3:0]  act;   // {change_out, milk, coffee, water}
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic coin_pulse(input int unit, input int idx);
    if (unit == 0) coin_in[idx] = 1'b1;
    else           coin_b[idx]  = 1'b1;
    tick();
    tick();
    coin_in = '0;
    coin_b  = '0;
    tick();
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ctrl   coin   sel   credit  cond   act
    vecs[0]  = '{8'h00, 2'b10, 2'd0, 12'd0,   6'h00, 4'h0};
    vecs[1]  = '{8'h00, 2'b10, 2'd0, 12'd0,   6'h00, 4'h0};
    vecs[2]  = '{8'h00, 2'b10, 2'd0, 12'd500, 6'h08, 4'h0};
    vecs[3]  = '{8'h00, 2'b10, 2'd0, 12'd500, 6'h08, 4'h0};
    vecs[4]  = '{8'h00, 2'b10, 2'd0, 12'd500, 6'h08, 4'h0};
    vecs[5]  = '{8'h00, 2'b00, 2'd2, 12'd500, 6'h08, 4'h0};
    vecs[6]  = '{8'h00, 2'b00, 2'd2, 12'd500, 6'h08, 4'h0};
    vecs[7]  = '{8'h02, 2'b00, 2'd2, 12'd500, 6'h0B, 4'h0};
    vecs[8]  = '{8'h04, 2'b00, 2'd2, 12'd100, 6'h0A, 4'h0};
    vecs[9]  = '{8'h00, 2'b01, 2'd3, 12'd100, 6'h0A, 4'h0};
    vecs[10] = '{8'h00, 2'b00, 2'd3, 12'd100, 6'h0A, 4'h0};
    vecs[11] = '{8'h00, 2'b01, 2'd3, 12'd200, 6'h0A, 4'h0};
    vecs[12] = '{8'h00, 2'b00, 2'd3, 12'd200, 6'h0A, 4'h0};
    vecs[13] = '{8'h00, 2'b00, 2'd3, 12'd300, 6'h0A, 4'h0};
    vecs[14] = '{8'h02, 2'b00, 2'd3, 12'd300, 6'h0A, 4'h0};
    vecs[15] = '{8'h04, 2'b00, 2'd3, 12'd300, 6'h2A, 4'h0};
    vecs[16] = '{8'h10, 2'b00, 2'd3, 12'd300, 6'h2A, 4'h0};
    vecs[17] = '{8'h01, 2'b00, 2'd3, 12'd0,   6'h02, 4'h0};
    vecs[18] = '{8'h10, 2'b00, 2'd3, 12'd0,   6'h02, 4'h1};
    vecs[19] = '{8'h60, 2'b00, 2'd3, 12'd0,   6'h02, 4'h6};
    vecs[20] = '{8'h00, 2'b00, 2'd2, 12'd0,   6'h02, 4'h0};
    vecs[21] = '{8'h00, 2'b00, 2'd2, 12'd0,   6'h02, 4'h0};
    vecs[22] = '{8'h02, 2'b00, 2'd2, 12'd0,   6'h02, 4'h0};

    tick();
    tick();
    check("reset_outputs", {credit, cond, change_out, milk, coffee, water}, 32'h0);
    check("reset_outputs_b", {credit_b, cond_b, change_b, milk_b, coffee_b, water_b}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ctrl    = vecs[i].ctrl;
      coin_in = vecs[i].coin;
      sel_in  = vecs[i].sel;
      tick();
      check($sformatf("vec%0d", i), {credit, cond, change_out, milk, coffee, water},
            {vecs[i].credit, vecs[i].cond, vecs[i].act});
    end
    ctrl = '0;

    // Drink 2 dispense time is 60 cycles.
    ctrl = 8'h08;
    tick();
    ctrl = '0;
    check("timer_start_clears_done", 32'(cond[2]), 32'd0);
    for (int i = 0; i < 59; i++) tick();
    check("timer_edge_59", 32'(cond[2]), 32'd0);
    tick();
    check("timer_edge_60", 32'(cond[2]), 32'd1);
    tick();
    check("timer_done_holds", 32'(cond[2]), 32'd1);

    for (int i = 0; i < 8; i++) coin_pulse(0, 1);
    check("credit_4000", 32'(credit), 32'd4000);
    check("no_fault_4000", 32'(cond[5]), 32'd0);
    coin_pulse(0, 1);
    check("credit_saturate", 32'(credit), 32'd4095);
    check("fault_saturate", 32'(cond[5]), 32'd1);
    ctrl = 8'h01;
    tick();
    ctrl = '0;
    check("clr_after_sat", {credit, cond[5]}, 32'd0);

    sel_in = 2'd1;
    tick();
    tick();
    ctrl = 8'h02;
    tick();
    ctrl = '0;
    for (int i = 0; i < 4; i++) coin_pulse(0, 0);
    check("credit_400", 32'(credit), 32'd400);
    coin_in = 2'b01;
    tick();
    coin_in = '0;
    tick();
    ctrl = 8'h04;
    tick();
    ctrl = '0;
    check("coin_with_deduct", 32'(credit), 32'd200);
    check("coin_with_deduct_nofault", 32'(cond[5]), 32'd0);

    ctrl = 8'h10;
    tick();
    check("water_on", 32'(water), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_water", 32'(water), 32'd0);
    check("async_reset_credit", 32'(credit), 32'd0);
    ctrl = '0;
    tick();
    rst = 1'b1;

    coin_pulse(0, 0);
    check("credit_100", 32'(credit), 32'd100);
    coin_in = 2'b01;
    tick();
    coin_in = '0;
    tick();
    ctrl = 8'h01;
    tick();
    ctrl = '0;
    check("clr_beats_coin", 32'(credit), 32'd0);
    tick();
    tick();
    check("clr_coin_lost", 32'(credit), 32'd0);

    cancel_in = 1'b1;
    tick();
    cancel_in = 1'b0;
    tick();
    check("cancel_edge2", 32'(cond[4]), 32'd0);
    tick();
    check("cancel_edge3", 32'(cond[4]), 32'(CancelExp));
    ctrl = 8'h01;
    tick();
    ctrl = '0;
    check("cancel_cleared", 32'(cond[4]), 32'd0);

    for (int i = 0; i < 5; i++) coin_pulse(1, 0);
    check("b_credit_250", {credit_b, cond_b[3]}, {12'd250, 1'b1});
    ctrl_b = 8'h80;
    tick();
    check("b_step1", {credit_b, cond_b[3], change_b}, {12'd150, 1'b1, 1'b1});
    tick();
    check("b_step2", {credit_b, cond_b[3], change_b}, {12'd50, 1'b0, 1'b1});
    tick();
    check("b_step3_forfeit", {credit_b, cond_b[3], change_b}, {12'd0, 1'b0, 1'b0});
    ctrl_b = '0;
    tick();
    check("b_idle", {credit_b, change_b, water_b, coffee_b, milk_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
